// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : Single-beat valid/ready host port to external asynchronous
//             8-bit SRAM. Sequences CS/OE/WE strobes over a shared
//             bidirectional data bus and returns read data with a
//             one-cycle response pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int WR_PULSE = 1,
    parameter int RD_WAIT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_address,
    inout  wire  [DATA_W-1:0] sram_data
);

    // Counter holds "cycles remaining minus one", so it needs only max-1 range
    localparam int c_CNT_MAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WR_PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_WAIT - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_WRITE = 3'd2;
    localparam logic [2:0] c_READ  = 3'd3;
    localparam logic [2:0] c_HOLD  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               op_we_q, op_we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               cs_q, cs_d;
    logic               oe_q, oe_d;
    logic               wen_q, wen_d;
    logic               drv_q, drv_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic w_accept;
    logic w_pulse_done;

    assign w_accept     = req_valid && (state_q == c_IDLE);
    assign w_pulse_done = (cnt_q == '0);

    // State register and strobe-length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; counter reloads as SETUP hands over to the strobe phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) state_d = c_SETUP;
            end
            c_SETUP: begin
                state_d = op_we_q ? c_WRITE : c_READ;
                cnt_d   = op_we_q ? c_WR_LOAD : c_RD_LOAD;
            end
            c_WRITE, c_READ: begin
                if (w_pulse_done) state_d = c_HOLD;
                else              cnt_d   = cnt_q - c_CNT_W'(1);
            end
            c_HOLD:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Output decode from the next state so every pin is driven straight from a flop
    always_comb begin
        op_we_d     = w_accept ? req_we    : op_we_q;
        addr_d      = w_accept ? req_addr  : addr_q;
        wdata_d     = w_accept ? req_wdata : wdata_q;
        cs_d        = (state_d != c_IDLE);
        oe_d        = (state_d != c_READ);
        wen_d       = (state_d != c_WRITE);
        // Bus is released in READ and IDLE, so it can never fight the SRAM
        drv_d       = op_we_d && (state_d != c_IDLE) && (state_d != c_READ);
        rsp_valid_d = (state_q == c_READ) && w_pulse_done;
        rsp_rdata_d = rsp_valid_d ? sram_data : rsp_rdata_q;
    end

    // Request payload, pin and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            oe_q        <= 1'b1;
            wen_q       <= 1'b1;
            drv_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            op_we_q     <= op_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            wen_q       <= wen_d;
            drv_q       <= drv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready    = (state_q == c_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign sram_cs      = !cs_q;
    assign sram_oe      = oe_q;
    assign sram_we      = wen_q;
    assign sram_address = addr_q;
    assign sram_data    = drv_q ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl
//  Purpose  : Self-checking bench for sram_ctrl with an SRAM array model,
//             a protocol monitor and a reference memory for read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam int WP = 3;
    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        sram_cs;
    logic        sram_oe;
    logic        sram_we;
    logic [15:0] sram_address;
    wire  [7:0]  sram_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] wq[$];

    logic [15:0] exp_addr  = '0;
    logic [7:0]  exp_wdata = '0;
    bit          last_we   = 1'b0;
    logic [7:0]  last_rd   = '0;

    sram_ctrl #(
        .ADDR_W  (16),
        .DATA_W  (8),
        .WR_PULSE(WP),
        .RD_WAIT (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .sram_cs     (sram_cs),
        .sram_oe     (sram_oe),
        .sram_we     (sram_we),
        .sram_address(sram_address),
        .sram_data   (sram_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM device: drives the bus while selected with OE low, stores while WE low
    assign sram_data = (!sram_cs && !sram_oe) ? mem[sram_address] : 8'hzz;
    always @(posedge clk) begin
        if (rst_n && !sram_cs && !sram_we) mem[sram_address] <= sram_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Protocol monitor, sampled mid-cycle after each rising edge
    int         we_run = 0, oe_run = 0, rdy_run = 0;
    logic       prev_cs = 1'b1;
    logic [15:0] prev_addr = '0;
    always @(posedge clk) begin
        #3;
        if (!rst_n) begin
            we_run = 0; oe_run = 0; rdy_run = 0; prev_cs = 1'b1;
        end else begin
            if (sram_cs) check("strobes_idle", {30'd0, sram_oe, sram_we}, 32'd3);
            else         check("addr", sram_address, exp_addr);
            if (!sram_cs && !prev_cs) check("addr_hold", sram_address, prev_addr);
            if (!sram_we) begin
                we_run++;
                check("bus_wr", sram_data, exp_wdata);
            end else if (we_run != 0) begin
                check("we_len", we_run, WP);
                we_run = 0;
            end
            if (!sram_oe) begin
                oe_run++;
                check("oe_we_excl", sram_we, 1);
            end else if (oe_run != 0) begin
                check("oe_len", oe_run, RW);
                oe_run = 0;
            end
            if (!req_ready) rdy_run++;
            else if (rdy_run != 0) begin
                check("ready_low", rdy_run, last_we ? WP + 2 : RW + 2);
                rdy_run = 0;
            end
            prev_cs   = sram_cs;
            prev_addr = sram_address;
        end
    end

    // Present a request at a falling edge; acc = cycle count of the accepting IDLE cycle
    task automatic issue(input bit we, input logic [15:0] a, input logic [7:0] d,
                         input bit keep, output int acc);
        bit ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        acc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                acc = cyc;
                exp_addr = a; exp_wdata = d; last_we = we;
                if (we) begin
                    ref_mem[a] = d;
                    wq.push_back(a);
                end
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 0, 1);
        if (!keep || !ok) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int acc, input logic [7:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                check("rsp_latency", cyc - acc, RW + 2);
                check("rsp_data", rsp_rdata, exp);
            end
            @(negedge clk);
        end
        if (!got) check("rsp_timeout", 0, 1);
        else      check("rsp_width", rsp_valid, 0);
        last_rd = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_cs", sram_cs, 1);
            check("rst_oe", sram_oe, 1);
            check("rst_we", sram_we, 1);
        end
        check("rst_addr", sram_address, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_ready", req_ready, 1);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed writes and reads, including the top address
        issue(1'b1, 16'h0001, 8'hAA, 1'b0, a1);
        issue(1'b0, 16'h0001, 8'h00, 1'b0, a1);
        wait_rsp(a1, 8'hAA);
        issue(1'b1, 16'h0002, 8'h55, 1'b0, a1);
        issue(1'b1, 16'hFFFF, 8'hC3, 1'b0, a1);
        check("rdata_held", rsp_rdata, last_rd);
        issue(1'b0, 16'h0002, 8'h00, 1'b0, a1);
        wait_rsp(a1, 8'h55);
        issue(1'b0, 16'hFFFF, 8'h00, 1'b0, a1);
        wait_rsp(a1, 8'hC3);
        issue(1'b0, 16'h0001, 8'h00, 1'b0, a1);
        wait_rsp(a1, 8'hAA);

        // Back-to-back with req_valid held: write then read of the same location
        issue(1'b1, 16'h0010, 8'h5A, 1'b1, a1);
        issue(1'b0, 16'h0010, 8'h00, 1'b0, a2);
        check("queued_accept_gap", a2 - a1, WP + 3);
        wait_rsp(a2, 8'h5A);

        // Reset in the middle of a read
        issue(1'b0, 16'h0002, 8'h00, 1'b0, a1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs", sram_cs, 1);
        check("midrst_oe", sram_oe, 1);
        check("midrst_we", sram_we, 1);
        check("midrst_rsp", rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_rsp_hold", rsp_valid, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_no_rsp", rsp_valid, 0);
        end
        check("postrst_rdata", rsp_rdata, 0);
        issue(1'b0, 16'h0001, 8'h00, 1'b0, a1);
        wait_rsp(a1, 8'hAA);

        // Randomized mix of writes and reads against the reference memory
        for (int n = 0; n < 40; n++) begin
            if (($urandom_range(0, 2) != 0) || (n == 39)) begin
                logic [15:0] ra;
                ra = wq[$urandom_range(0, wq.size() - 1)];
                issue(1'b0, ra, 8'h00, 1'b0, a1);
                wait_rsp(a1, ref_mem[ra]);
            end else begin
                logic [15:0] wa;
                logic [7:0]  wd;
                wa = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
                wd = 8'($urandom);
                issue(1'b1, wa, wd, 1'($urandom_range(0, 1)), a1);
                check("rand_rdata_held", rsp_rdata, last_rd);
            end
        end

        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
